// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment scanner: per-digit slot with a leading anode-off
// guard, a slot-start snapshot of the digit, and fully registered outputs.

package seven_seg_pkg;
    typedef struct packed {
        logic [3:0] nib;
        logic       dp;
        logic       blank;
    } slot_t;

    typedef enum logic {GUARD, SHOW} phase_t;
endpackage

// Per-digit lane: folds the forced blank and leading-zero blanking into one flag.
module seven_seg_lane
    import seven_seg_pkg::*;
#(
    parameter int K      = 0,
    parameter bit LZB_EN = 1'b0
) (
    input  logic [3:0] nib,
    input  logic       dp_req,
    input  logic       blank_req,
    input  logic       lead_zero,
    output slot_t      slot
);
    logic lzb;

    // A requested dp keeps an otherwise-leading zero visible.
    assign lzb  = LZB_EN && (K > 0) && lead_zero && !dp_req;
    assign slot = '{nib: nib, dp: dp_req, blank: blank_req | lzb};
endmodule

// Active-high {a..g} decode; 10-15 fall back to a dash unless hex is enabled.
module seven_seg_decode #(
    parameter bit HEX_MODE = 1'b0
) (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b0000001;
        case (nib)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'ha: if (HEX_MODE) seg = 7'b1110111;
            4'hb: if (HEX_MODE) seg = 7'b0011111;
            4'hc: if (HEX_MODE) seg = 7'b1001110;
            4'hd: if (HEX_MODE) seg = 7'b0111101;
            4'he: if (HEX_MODE) seg = 7'b1001111;
            4'hf: if (HEX_MODE) seg = 7'b1000111;
            default: seg = 7'b0000001;
        endcase
    end
endmodule

module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int HEX_MODE       = 0,
    parameter int LZB_EN         = 0,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digitsIn,
    input  logic [NUM_DIGITS-1:0]   dpIn,
    input  logic [NUM_DIGITS-1:0]   blankIn,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [2:0]              digitIdx,
    output logic                    frameStart
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CW-1:0]         CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]         BC      = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0]         IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    logic [CW-1:0]                 cnt;
    logic [IW-1:0]                 idx;
    logic [NUM_DIGITS-1:0][3:0]    dig;
    logic [NUM_DIGITS:0]           lead_zero;
    slot_t [NUM_DIGITS-1:0]        lane;
    slot_t                         snap, cur;
    phase_t                        phase;
    logic                          first_show;
    logic [6:0]                    dec;
    logic [6:0]                    seg_n;
    logic                          dp_n;
    logic [NUM_DIGITS-1:0]         an_n;

    assign dig                   = digitsIn;
    assign lead_zero[NUM_DIGITS] = 1'b1;

    // lead_zero[k]: digit k and every more-significant digit are zero.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
        assign lead_zero[k] = lead_zero[k+1] && (dig[k] == 4'd0);

        seven_seg_lane #(
            .K     (k),
            .LZB_EN(LZB_EN != 0)
        ) u_lane (
            .nib      (dig[k]),
            .dp_req   (dpIn[k]),
            .blank_req(blankIn[k]),
            .lead_zero(lead_zero[k]),
            .slot     (lane[k])
        );
    end

    if (BLANK_CYCLES == 0) begin : g_noguard
        assign phase = SHOW;
    end else begin : g_guard
        assign phase = (cnt < BC) ? GUARD : SHOW;
    end

    // First SHOW clock displays the live digit and latches it for the rest of the slot.
    assign first_show = (cnt == BC);
    assign cur        = first_show ? lane[idx] : snap;

    seven_seg_decode #(.HEX_MODE(HEX_MODE != 0)) u_dec (
        .nib(cur.nib),
        .seg(dec)
    );

    always_comb begin
        seg_n = 7'h00;
        dp_n  = 1'b0;
        an_n  = '0;
        if (phase == SHOW) begin
            an_n[idx] = 1'b1;
            if (!cur.blank) begin
                seg_n = dec;
                dp_n  = cur.dp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt        <= '0;
            idx        <= '0;
            snap       <= '0;
            segments   <= SEG_OFF;
            dp         <= DP_OFF;
            anodes     <= AN_OFF;
            digitIdx   <= 3'd0;
            frameStart <= 1'b0;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (first_show) snap <= lane[idx];
            segments   <= seg_n ^ SEG_OFF;
            dp         <= dp_n ^ DP_OFF;
            anodes     <= an_n ^ AN_OFF;
            digitIdx   <= 3'(idx);
            frameStart <= (cnt == '0) && (idx == '0);
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: two scanner builds (hex+LZB, plain) share inputs; expected
// outputs come from a clock-count model of the scan frame.
module tb_seven_seg_scanner;
    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic [2:0] idx;
        logic       fs;
    } out_t;

    typedef struct packed {
        out_t h;
        out_t d;
    } pair_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] digitsIn = '0;
    logic [3:0]  dpIn = '0;
    logic [3:0]  blankIn = '0;

    logic [6:0] seg_h, seg_d;
    logic       dp_h, dp_d;
    logic [3:0] an_h, an_d;
    logic [2:0] idx_h, idx_d;
    logic       fs_h, fs_d;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2), .HEX_MODE(1), .LZB_EN(1),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut_h (
        .clk(clk), .reset(reset), .enable(enable), .digitsIn(digitsIn), .dpIn(dpIn),
        .blankIn(blankIn), .segments(seg_h), .dp(dp_h), .anodes(an_h),
        .digitIdx(idx_h), .frameStart(fs_h)
    );

    seven_seg_scanner #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2), .HEX_MODE(0), .LZB_EN(0),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut_d (
        .clk(clk), .reset(reset), .enable(enable), .digitsIn(digitsIn), .dpIn(dpIn),
        .blankIn(blankIn), .segments(seg_d), .dp(dp_d), .anodes(an_d),
        .digitIdx(idx_d), .frameStart(fs_d)
    );

    // Active-high glyphs indexed by value: 0-9 then A,b,C,d,E,F.
    logic [6:0] glyph [0:15];
    initial begin
        glyph[0]  = 7'b1111110; glyph[1]  = 7'b0110000; glyph[2]  = 7'b1101101;
        glyph[3]  = 7'b1111001; glyph[4]  = 7'b0110011; glyph[5]  = 7'b1011011;
        glyph[6]  = 7'b1011111; glyph[7]  = 7'b1110000; glyph[8]  = 7'b1111111;
        glyph[9]  = 7'b1111011; glyph[10] = 7'b1110111; glyph[11] = 7'b0011111;
        glyph[12] = 7'b1001110; glyph[13] = 7'b0111101; glyph[14] = 7'b1001111;
        glyph[15] = 7'b1000111;
    end

    pair_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    string phase_name = "reset";

    // Scan model state: clocks elapsed since the scan (re)started, plus the slot snapshot.
    int         t = 0;
    logic [3:0] s_nib = '0;
    logic       s_dp = 1'b0;
    bit         s_blk_h = 1'b0, s_blk_d = 1'b0;

    // Shadow inputs, applied to the DUTs on the next falling edge.
    logic [15:0] nd = '0;
    logic [3:0]  ndp = '0, nbl = '0;

    function automatic bit lzb_blank(input logic [15:0] d, input logic [3:0] dpv, input int k);
        if (k == 0 || dpv[k]) return 1'b0;
        for (int j = k; j < 4; j++)
            if (d[4*j +: 4] != 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic out_t blank_out();
        out_t o;
        o.seg = 7'h7f; o.dp = 1'b1; o.an = 4'hf; o.idx = 3'd0; o.fs = 1'b0;
        return o;
    endfunction

    function automatic out_t mk(input int tc, input logic [3:0] nib, input logic dpb,
                                input bit blk, input bit hex);
        out_t o;
        int slot, pos;
        logic [6:0] g;
        slot  = (tc / 8) % 4;
        pos   = tc % 8;
        o.idx = 3'(slot);
        o.fs  = (tc % 32) == 0;
        g     = (!hex && nib > 4'd9) ? 7'b0000001 : glyph[nib];
        if (pos < 2) begin
            o.seg = 7'h7f; o.dp = 1'b1; o.an = 4'hf;
        end else begin
            o.an  = ~(4'b0001 << slot);
            o.seg = blk ? 7'h7f : ~g;
            o.dp  = blk ? 1'b1 : ~dpb;
        end
        return o;
    endfunction

    task automatic cyc(input bit r, input bit e);
        pair_t p;
        int slot;
        @(negedge clk);
        reset = r; enable = e; digitsIn = nd; dpIn = ndp; blankIn = nbl;
        if (r || !e) begin
            p.h = blank_out(); p.d = blank_out();
            t = 0;
        end else begin
            slot = (t / 8) % 4;
            if (t % 8 == 2) begin
                s_nib   = nd[4*slot +: 4];
                s_dp    = ndp[slot];
                s_blk_d = nbl[slot];
                s_blk_h = nbl[slot] | lzb_blank(nd, ndp, slot);
            end
            p.h = mk(t, s_nib, s_dp, s_blk_h, 1'b1);
            p.d = mk(t, s_nib, s_dp, s_blk_d, 1'b0);
            t++;
        end
        exp_q.push_back(p);
    endtask

    always @(posedge clk) begin
        pair_t p;
        out_t  gh, gd;
        #1;
        if (exp_q.size() > 0) begin
            p  = exp_q.pop_front();
            gh = {seg_h, dp_h, an_h, idx_h, fs_h};
            gd = {seg_d, dp_d, an_d, idx_d, fs_d};
            tests += 2;
            if (gh !== p.h) begin
                fails++;
                $display("FAIL %s hexlzb @%0t got seg/dp/an/idx/fs=%b want %b",
                         phase_name, $time, gh, p.h);
            end
            if (gd !== p.d) begin
                fails++;
                $display("FAIL %s plain @%0t got seg/dp/an/idx/fs=%b want %b",
                         phase_name, $time, gd, p.d);
            end
        end
    end

    initial begin
        repeat (3) cyc(1'b1, 1'b0);

        phase_name = "basic_4321";
        nd = 16'h4321;
        repeat (64) cyc(1'b0, 1'b1);

        phase_name = "hex_00AF";
        nd = 16'h00AF;
        repeat (40) cyc(1'b0, 1'b1);

        phase_name = "lzb_0050";
        nd = 16'h0050;
        repeat (32) cyc(1'b0, 1'b1);
        phase_name = "lzb_dp3";
        ndp = 4'b1000;
        repeat (32) cyc(1'b0, 1'b1);

        phase_name = "midslot_change";
        ndp = 4'b0000; nd = 16'h4321;
        for (int i = 0; i < 40 && (t % 32) != 12; i++) cyc(1'b0, 1'b1);
        nd = 16'h8765;
        repeat (64) cyc(1'b0, 1'b1);

        phase_name = "reset_midslot";
        for (int i = 0; i < 40 && (t % 32) != 21; i++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        repeat (10) cyc(1'b0, 1'b1);

        phase_name = "enable_drop";
        repeat (13) cyc(1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        repeat (40) cyc(1'b0, 1'b1);

        phase_name = "random";
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int j = 0; j < 4; j++)
                    nd[4*j +: 4] = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
                ndp = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
                nbl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            end
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 79) != 0);
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4, is the number of multiplexed digits; legal range is 1..8.
REQ-002 Parameter SCAN_DIV, default 50000, is the number of clocks per digit slot; it SHALL be greater than BLANK_CYCLES.
REQ-003 Parameter BLANK_CYCLES, default 2, is the ghosting guard: the number of clocks at the start of each slot with all anodes off; legal range is 0..SCAN_DIV-1.
REQ-004 Parameter HEX_MODE, default 0: 1 decodes values 10-15 as A,b,C,d,E,F; 0 shows a dash for them.
REQ-005 Parameter LZB_EN, default 0: 1 enables leading-zero blanking.
REQ-006 Parameter SEG_ACTIVE_LOW, default 1, sets the polarity of segments and dp.
REQ-007 Parameter AN_ACTIVE_LOW, default 1, sets the polarity of anodes.
REQ-008 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-009 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 Port enable, input, 1 bit: scanning enable.
REQ-011 Port digitsIn, input, 4*NUM_DIGITS bits: nibble k at [4k+3:4k] is digit k, with digit 0 least significant.
REQ-012 Port dpIn, input, NUM_DIGITS bits: decimal-point request per digit.
REQ-013 Port blankIn, input, NUM_DIGITS bits: forced blank per digit.
REQ-014 Port segments, output, 7 bits, registered: bit order {a,b,c,d,e,f,g}, with a at bit 6.
REQ-015 Port dp, output, 1 bit, registered: decimal-point segment.
REQ-016 Port anodes, output, NUM_DIGITS bits, registered: one-hot digit select.
REQ-017 Port digitIdx, output, 3 bits, registered: index of the current slot.
REQ-018 Port frameStart, output, 1 bit, registered: one-clock pulse at the start of slot 0.

Function
REQ-019 Internal state SHALL be a prescaler cnt (0..SCAN_DIV-1) and a slot index idx (0..NUM_DIGITS-1).
REQ-020 While enable=1, cnt SHALL increment every clock.
REQ-021 When cnt=SCAN_DIV-1, cnt SHALL wrap to 0 and idx SHALL advance; idx=NUM_DIGITS-1 SHALL wrap to 0.
REQ-022 State GUARD (cnt<BLANK_CYCLES) SHALL drive all anodes inactive and all segments and dp off.
REQ-023 State SHOW (cnt>=BLANK_CYCLES) SHALL drive anode idx active and all other anodes inactive.
REQ-024 The nibble, dp bit and blank bit for digit idx SHALL be snapshotted on the first SHOW clock and held constant for the rest of the slot; input changes mid-slot SHALL NOT alter the displayed digit.
REQ-025 Outputs SHALL be registered with exactly 1 clock latency from the cnt/idx state that selects them.
REQ-026 Decode, active-high, {a..g}:
- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
- 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- HEX_MODE=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- HEX_MODE=0, values 10-15: dash 0000001
REQ-027 When SEG_ACTIVE_LOW=1, segments and dp SHALL be the bitwise inverse of active-high; when AN_ACTIVE_LOW=1, anodes SHALL be inverted likewise.
REQ-028 Blanked digit: a digit with blankIn[k]=1 SHALL show all segments off, dp included, with its anode still active.
REQ-029 Leading-zero blanking: with LZB_EN=1, digit k>0 SHALL be blanked when it and every more-significant digit equal 0; digit 0 is never blanked by this rule, and dpIn[k]=1 exempts digit k.
REQ-030 frameStart SHALL be 1 for exactly the one output clock corresponding to cnt=0, idx=0.
REQ-031 When enable=0, cnt and idx SHALL clear to 0 and outputs SHALL take their reset values; the next enable=1 starts a fresh GUARD of slot 0.
REQ-032 When NUM_DIGITS=1, idx SHALL stay 0 and frameStart SHALL pulse once every SCAN_DIV clocks.

Reset
REQ-033 A clock edge with reset=1 SHALL set cnt=0, idx=0, digitIdx=0, frameStart=0, all anodes inactive, and segments and dp off, in the configured polarities; reset overrides enable.
REQ-034 Reset asserted mid-slot SHALL blank the outputs on that same edge, and scanning SHALL restart at the GUARD of slot 0 on the first edge after release.

Verification (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, active-low, unless stated)
REQ-035 Release reset, enable=1, digitsIn=16'h4321 -> per 8-clock slot: 2 clocks anodes=1111, then 6 clocks with anodes 1110/1101/1011/0111 and segments 1001111/0010010/0000110/1001100; frameStart pulses every 32 clocks.
REQ-036 HEX_MODE=0, digitsIn=16'h00AF -> digits 0 and 1 show 1111110 (dash); HEX_MODE=1 -> F=0111000, A=0001000.
REQ-037 LZB_EN=1, digitsIn=16'h0050 -> digits 3 and 2 blank (segments 1111111), digit 1 shows 5, digit 0 shows 0; setting dpIn[3]=1 makes digit 3 show 0 with dp=0.
REQ-038 Change digitsIn on the 3rd SHOW clock of slot 1 -> slot 1 output is unchanged; slot 1 of the next frame shows the new value.
REQ-039 Assert reset at cnt=5, idx=2 -> next output anodes=1111 and segments=1111111; after release the first active anode is 1110, 3 clocks later, since output is registered.
REQ-040 Drop enable for 3 clocks mid-frame -> outputs are blank while enable is low; after re-enable, slot 0 restarts and frameStart pulses.
